fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter BUS_SIZE, default 32, datapath/address width.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-003 SHALL have parameter HALT_WORD, default all-ones, instruction encoding that halts fetch.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle pulse, begins fetching from IDLE.
REQ-007 SHALL have port stall  input  1  hazard hold of PC and IF/ID outputs.
REQ-008 SHALL have port flush  input  1  squash IF/ID contents (taken branch/jump).
REQ-009 SHALL have port redirect  input  1  load redirect_pc into PC.
REQ-010 SHALL have port redirect_pc  input  BUS_SIZE  branch/jump target.
REQ-011 SHALL have port imem_addr  output  BUS_SIZE  instruction memory address, equal to PC.
REQ-012 SHALL have port imem_data  input  BUS_SIZE  instruction word, combinational read of imem_addr.
REQ-013 SHALL have port instr  output  BUS_SIZE  registered IF/ID instruction.
REQ-014 SHALL have port pc_plus4  output  BUS_SIZE  registered IF/ID PC+4.
REQ-015 SHALL have port valid  output  1  IF/ID holds a real instruction.
REQ-016 SHALL have port halted  output  1  high while in HALT state.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, HALT; IDLE->RUN on start; RUN->HALT on halt detection; HALT->RUN on redirect; start ignored outside IDLE.
REQ-018 SHALL compute PC+4 modulo 2^BUS_SIZE (all-ones-minus-3 wraps to 0), no carry out.
REQ-019 SHALL define advance = (state RUN) & !stall & !flush & !redirect.
REQ-020 SHALL on advance: PC<=PC+4, instr<=imem_data, pc_plus4<=PC+4, valid<=1; one-cycle latency from imem_addr to instr.
REQ-021 SHALL on redirect in RUN or HALT: PC<=redirect_pc regardless of stall, state<=RUN.
REQ-022 SHALL on flush: instr<=0 (NOP), pc_plus4<=0, valid<=0 regardless of stall; flush does not alter PC unless redirect also asserted.
REQ-023 SHALL on stall without flush/redirect: hold PC, instr, pc_plus4, valid unchanged.
REQ-024 SHALL detect halt when advance and imem_data==HALT_WORD: latch halt word into IF/ID with valid=1, hold PC at halt address, state<=HALT.
REQ-025 SHALL in HALT (no redirect): hold PC, load IF/ID with NOP, valid=0 each cycle, halted=1.
REQ-026 SHALL ignore a HALT_WORD on a cycle with flush or redirect (squashed, no state change to HALT).
REQ-027 SHALL in IDLE: hold PC at RESET_PC, valid=0, ignore stall/flush/redirect.

Reset
REQ-028 SHALL on reset_n low, immediately: state=IDLE, PC=RESET_PC, instr=0, pc_plus4=0, valid=0, halted=0.
REQ-029 SHALL abort any operation on reset mid-fetch or in HALT; no partial IF/ID update after release.
REQ-030 SHALL first accept start on the first rising edge with reset_n high.

Configuration
REQ-031 SHALL, with FETCH_STEP_EN defined, add inputs step_mode (1) and step (1); when step_mode=1 advance additionally requires step=1, one instruction per step pulse; redirect/flush unaffected.
REQ-032 SHALL, without FETCH_STEP_EN, omit step_mode and step ports and behave as step_mode=0.

Verification
REQ-033 SHALL test reset then start, imem returns 0x11111111,0x22222222 -> imem_addr 0,4,8; instr 0x11111111 with pc_plus4 4, then 0x22222222 with pc_plus4 8, valid=1.
REQ-034 SHALL test stall 3 cycles at PC=0x10 -> imem_addr, instr, pc_plus4 frozen 3 cycles, resume at 0x14 after.
REQ-035 SHALL test redirect+flush with stall high, redirect_pc=0x100 -> next imem_addr=0x100, instr=0, valid=0.
REQ-036 SHALL test imem_data=0xFFFFFFFF at PC=0x20 -> instr=0xFFFFFFFF valid=1, then halted=1, imem_addr stays 0x20, valid=0; later redirect to 0x40 -> halted=0, fetch from 0x40.
REQ-037 SHALL test RESET_PC=0xFFFFFFFC, start -> second imem_addr=0x0 (wrap).
REQ-038 SHALL test reset_n low mid-RUN at PC=0x30 -> outputs zero asynchronously, imem_addr=RESET_PC, start required again.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage with IDLE/RUN/HALT control, IF/ID
//                pipeline register, stall/flush/redirect handling and
//                halt-word detection. Optional single-step gating is enabled
//                by defining FETCH_STEP_EN (adds step_mode/step inputs).
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                  BUS_SIZE  = 32,
    parameter logic [BUS_SIZE-1:0] RESET_PC  = '0,
    parameter logic [BUS_SIZE-1:0] HALT_WORD = '1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect,
    input  logic [BUS_SIZE-1:0] redirect_pc,
`ifdef FETCH_STEP_EN
    input  logic                step_mode,
    input  logic                step,
`endif
    output logic [BUS_SIZE-1:0] imem_addr,
    input  logic [BUS_SIZE-1:0] imem_data,
    output logic [BUS_SIZE-1:0] instr,
    output logic [BUS_SIZE-1:0] pc_plus4,
    output logic                valid,
    output logic                halted
);

    localparam logic [BUS_SIZE-1:0] c_pc_step = BUS_SIZE'(4);
    localparam logic [BUS_SIZE-1:0] c_nop     = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BUS_SIZE-1:0] pc_q, pc_d;
    logic [BUS_SIZE-1:0] instr_q, instr_d;
    logic [BUS_SIZE-1:0] pc_plus4_q, pc_plus4_d;
    logic                valid_q, valid_d;
    logic                halted_q, halted_d;

    logic                w_step_ok;
    logic                w_advance;
    logic                w_is_halt;
    logic [BUS_SIZE-1:0] w_pc_inc;

`ifdef FETCH_STEP_EN
    // In step mode a fetch may only proceed on a step pulse.
    assign w_step_ok = !step_mode || step;
`else
    assign w_step_ok = 1'b1;
`endif

    // Increment wraps naturally at the top of the address space.
    assign w_pc_inc  = pc_q + c_pc_step;
    assign w_advance = (state_q == ST_RUN) && !stall && !flush && !redirect && w_step_ok;
    assign w_is_halt = (imem_data == HALT_WORD);

    // Next-state and next-IF/ID computation for the fetch control FSM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        halted_d   = halted_q;

        unique case (state_q)
            ST_IDLE: begin
                // Stall/flush/redirect have no meaning before start.
                pc_d    = RESET_PC;
                valid_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (flush) begin
                    instr_d    = c_nop;
                    pc_plus4_d = '0;
                    valid_d    = 1'b0;
                end else if (w_advance) begin
                    instr_d    = imem_data;
                    pc_plus4_d = w_pc_inc;
                    valid_d    = 1'b1;
                    if (w_is_halt) begin
                        // PC parks on the halt word's address.
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = w_pc_inc;
                    end
                end else if (!stall) begin
                    // Redirect without flush, or a withheld step: issue a
                    // bubble so the consumer never sees a duplicate.
                    instr_d    = c_nop;
                    pc_plus4_d = '0;
                    valid_d    = 1'b0;
                end
            end

            ST_HALT: begin
                instr_d    = c_nop;
                pc_plus4_d = '0;
                valid_d    = 1'b0;
                if (redirect) begin
                    pc_d     = redirect_pc;
                    state_d  = ST_RUN;
                    halted_d = 1'b0;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                pc_d     = RESET_PC;
                valid_d  = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    // State and IF/ID register, cleared immediately on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= c_nop;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign pc_plus4  = pc_plus4_q;
    assign valid     = valid_q;
    assign halted    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit (table-driven vectors with
//                a fetch scoreboard, plus reset and address-wrap sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_data, instr, pc_plus4;
    logic        valid, halted;

    logic        start_w;
    logic [31:0] imem_addr_w, imem_data_w, instr_w, pc_plus4_w;
    logic        valid_w, halted_w;

    logic [31:0] mem [0:127];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign imem_data   = mem[imem_addr[8:2]];
    assign imem_data_w = mem[imem_addr_w[8:2]];

    fetch_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stall      (stall),
        .flush      (flush),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
`ifdef FETCH_STEP_EN
        .step_mode  (1'b0),
        .step       (1'b0),
`endif
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .instr      (instr),
        .pc_plus4   (pc_plus4),
        .valid      (valid),
        .halted     (halted)
    );

    fetch_unit #(.BUS_SIZE(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_w),
        .stall      (1'b0),
        .flush      (1'b0),
        .redirect   (1'b0),
        .redirect_pc(32'h0),
`ifdef FETCH_STEP_EN
        .step_mode  (1'b0),
        .step       (1'b0),
`endif
        .imem_addr  (imem_addr_w),
        .imem_data  (imem_data_w),
        .instr      (instr_w),
        .pc_plus4   (pc_plus4_w),
        .valid      (valid_w),
        .halted     (halted_w)
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic        exp_valid;
        logic        exp_halted;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] rpc,
                                input logic [31:0] a, input logic [31:0] i, input logic [31:0] p,
                                input logic v, input logic h);
        vec_t t;
        t.stall = s; t.flush = f; t.redirect = r; t.rpc = rpc;
        t.exp_addr = a; t.exp_instr = i; t.exp_pc4 = p; t.exp_valid = v; t.exp_halted = h;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] prev_addr;
        logic        model_halted;
        logic        adv;
        sb_t         e;

        for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | 32'(i * 4);
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[8] = 32'hFFFF_FFFF;   // halt word at 0x20

        // Rows start with the DUT in RUN at PC 0 and an empty IF/ID.
        vecs.push_back(mk(0,0,0,0,   32'h04, 0, 0, 1, 0));
        vecs.push_back(mk(0,0,0,0,   32'h08, 0, 0, 1, 0));
        vecs.push_back(mk(0,0,0,0,   32'h0C, 0, 0, 1, 0));
        vecs.push_back(mk(0,0,0,0,   32'h10, 0, 0, 1, 0));
        vecs.push_back(mk(1,0,0,0,   32'h10, 32'hA000_000C, 32'h10, 1, 0));
        vecs.push_back(mk(1,0,0,0,   32'h10, 32'hA000_000C, 32'h10, 1, 0));
        vecs.push_back(mk(1,0,0,0,   32'h10, 32'hA000_000C, 32'h10, 1, 0));
        vecs.push_back(mk(0,0,0,0,   32'h14, 0, 0, 1, 0));
        vecs.push_back(mk(0,0,0,0,   32'h18, 0, 0, 1, 0));
        vecs.push_back(mk(0,0,0,0,   32'h1C, 0, 0, 1, 0));
        vecs.push_back(mk(0,0,0,0,   32'h20, 0, 0, 1, 0));
        vecs.push_back(mk(0,0,0,0,   32'h20, 0, 0, 1, 1));     // halt word latched
        vecs.push_back(mk(0,0,0,0,   32'h20, 0, 0, 0, 1));
        vecs.push_back(mk(1,0,0,0,   32'h20, 0, 0, 0, 1));
        vecs.push_back(mk(0,1,0,0,   32'h20, 0, 0, 0, 1));
        vecs.push_back(mk(0,1,1,32'h40, 32'h40, 0, 0, 0, 0));  // leave HALT
        vecs.push_back(mk(0,0,0,0,   32'h44, 0, 0, 1, 0));
        vecs.push_back(mk(0,0,0,0,   32'h48, 0, 0, 1, 0));
        vecs.push_back(mk(1,1,1,32'h100, 32'h100, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,   32'h104, 0, 0, 1, 0));
        vecs.push_back(mk(0,1,0,0,   32'h104, 0, 0, 0, 0));    // flush keeps PC
        vecs.push_back(mk(0,0,0,0,   32'h108, 0, 0, 1, 0));
        vecs.push_back(mk(0,1,1,32'h20, 32'h20, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0,   32'h20, 0, 0, 0, 0));     // halt word squashed
        vecs.push_back(mk(0,1,1,32'h2C, 32'h2C, 0, 0, 0, 0));  // halt word squashed
        vecs.push_back(mk(0,0,0,0,   32'h30, 0, 0, 1, 0));

        reset_n = 1'b0; start = 0; stall = 0; flush = 0; redirect = 0; redirect_pc = 0; start_w = 0;
        #12;
        check("rst_addr",   imem_addr, 32'h0);
        check("rst_instr",  instr,     32'h0);
        check("rst_pc4",    pc_plus4,  32'h0);
        check("rst_valid",  32'(valid),  32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_addr_w", imem_addr_w, 32'hFFFF_FFFC);
        reset_n = 1'b1;

        // IDLE must ignore stall/flush/redirect.
        stall = 1; flush = 1; redirect = 1; redirect_pc = 32'h80;
        tick();
        check("idle_addr",  imem_addr, 32'h0);
        check("idle_valid", 32'(valid), 32'h0);
        stall = 0; flush = 0; redirect = 0; redirect_pc = 0;

        start = 1;
        tick();
        start = 0;
        check("start_addr",  imem_addr, 32'h0);
        check("start_valid", 32'(valid), 32'h0);

        prev_addr    = 32'h0;
        model_halted = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].stall; flush = vecs[i].flush;
            redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
            adv = !vecs[i].stall && !vecs[i].flush && !vecs[i].redirect && !model_halted;
            if (adv) begin
                e.instr = mem[prev_addr[8:2]];
                e.pc4   = prev_addr + 32'd4;
                sb.push_back(e);
            end
            tick();
            check($sformatf("v%0d_addr", i),   imem_addr,    vecs[i].exp_addr);
            check($sformatf("v%0d_valid", i),  32'(valid),   32'(vecs[i].exp_valid));
            check($sformatf("v%0d_halted", i), 32'(halted),  32'(vecs[i].exp_halted));
            if (adv) begin
                if (sb.size() == 0) begin
                    check($sformatf("v%0d_sb_empty", i), 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("v%0d_sb_instr", i), instr,    e.instr);
                    check($sformatf("v%0d_sb_pc4", i),   pc_plus4, e.pc4);
                end
            end else begin
                check($sformatf("v%0d_instr", i), instr,    vecs[i].exp_instr);
                check($sformatf("v%0d_pc4", i),   pc_plus4, vecs[i].exp_pc4);
            end
            prev_addr    = vecs[i].exp_addr;
            model_halted = vecs[i].exp_halted;
        end
        stall = 0; flush = 0; redirect = 0; redirect_pc = 0;

        // Asynchronous reset in the middle of a RUN cycle at PC 0x30.
        #2 reset_n = 1'b0;
        #1;
        check("arst_addr",  imem_addr, 32'h0);
        check("arst_instr", instr,     32'h0);
        check("arst_pc4",   pc_plus4,  32'h0);
        check("arst_valid", 32'(valid), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("nostart_addr",  imem_addr, 32'h0);
        check("nostart_valid", 32'(valid), 32'h0);
        start = 1;
        tick();
        start = 0;
        check("restart_addr", imem_addr, 32'h0);
        tick();
        check("restart_instr", instr,     32'h1111_1111);
        check("restart_pc4",   pc_plus4,  32'h4);
        check("restart_valid", 32'(valid), 32'h1);
        check("restart_addr2", imem_addr, 32'h4);

        // PC wrap from the top of the address space.
        start_w = 1;
        tick();
        start_w = 0;
        check("wrap_addr0", imem_addr_w, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr1", imem_addr_w, 32'h0);
        check("wrap_instr", instr_w,     32'hA000_01FC);
        check("wrap_pc4",   pc_plus4_w,  32'h0);
        check("wrap_valid", 32'(valid_w), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
